// File: rtl/test_rd_req_arbiter.sv
// -----------------------------------------------------------------------------
// test_rd_req_arbiter
//
// Round-robin arbiter that shares the CCI-P c0 read-request channel between
// N_REQ test engines. Each issued request carries Mdata = {index, tag}. The
// arbiter uses that index to send each read response back to the requester
// that issued it.
//
// Optional feature macro: TEST_RD_ARB_CREDIT_EN
//   defined   : a per-requester outstanding-read counter is kept. A requester
//               that holds MAX_OUTSTANDING reads is skipped by the round robin.
//               idle is derived from these counters.
//   undefined : no per-requester limit. idle is derived from a single 16-bit
//               total-outstanding counter.
//
// Ports
//   clk, reset           AFU clock, synchronous active-high reset
//   req_valid/addr/tag   per-requester request, requester i at slice i
//   req_grant            combinational one-hot accept
//   c0_tx_valid/addr/mdata  registered read request to MPF
//   c0_tx_almfull        MPF c0TxAlmFull; blocks all grants while high
//   c0_rx_valid/mdata/data  read response from MPF
//   rsp_valid/tag/data   registered response, one-hot by requester
//   bad_rsp              sticky flag for a response whose index >= N_REQ
//   idle                 no outstanding reads and no request in flight
// -----------------------------------------------------------------------------
module test_rd_req_arbiter #(
    parameter int N_REQ           = 4,
    parameter int ADDR_W          = 42,
    parameter int TAG_W           = 12,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*ADDR_W-1:0]           req_addr,
    input  logic [N_REQ*TAG_W-1:0]            req_tag,
    output logic [N_REQ-1:0]                  req_grant,
    output logic                              c0_tx_valid,
    output logic [ADDR_W-1:0]                 c0_tx_addr,
    output logic [TAG_W+$clog2(N_REQ)-1:0]    c0_tx_mdata,
    input  logic                              c0_tx_almfull,
    input  logic                              c0_rx_valid,
    input  logic [TAG_W+$clog2(N_REQ)-1:0]    c0_rx_mdata,
    input  logic [511:0]                      c0_rx_data,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [TAG_W-1:0]                  rsp_tag,
    output logic [511:0]                      rsp_data,
    output logic                              bad_rsp,
    output logic                              idle
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int MD_W  = TAG_W + IDX_W;

    if (N_REQ < 2 || N_REQ > 8 || MAX_OUTSTANDING < 1 || MD_W > 16) begin : g_param_check
        $error("test_rd_req_arbiter: unsupported parameter combination");
    end

    // Per-requester views of the flattened request buses
    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [TAG_W-1:0]  tag_a  [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
            tag_a[i]  = req_tag[i*TAG_W +: TAG_W];
        end
    end

    // Registered state
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic              tx_valid_q;
    logic [ADDR_W-1:0] tx_addr_q;
    logic [MD_W-1:0]   tx_mdata_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [511:0]      rsp_data_q;
    logic              bad_q;

    // Response decode
    logic [IDX_W-1:0] rx_idx;
    logic             rx_ok;
    logic [N_REQ-1:0] rx_hit;

    always_comb begin
        rx_idx = c0_rx_mdata[MD_W-1:TAG_W];
        // The index is widened by one bit so that the comparison holds for
        // every N_REQ, including powers of two.
        rx_ok  = c0_rx_valid && ({1'b0, rx_idx} < (IDX_W+1)'(N_REQ));
        for (int i = 0; i < N_REQ; i++) begin
            rx_hit[i] = rx_ok && (rx_idx == IDX_W'(i));
        end
    end

    // Outstanding-read accounting
    logic [N_REQ-1:0] has_credit;
    logic             none_outstanding;
    logic             found;

`ifdef TEST_RD_ARB_CREDIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    always_comb begin
        none_outstanding = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            has_credit[i] = (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
            if (cnt_q[i] != '0) begin
                none_outstanding = 1'b0;
            end
            // Grant and response in the same cycle cancel. A response for a
            // read abandoned by reset finds the count at 0 and leaves it there.
            cnt_d[i] = cnt_q[i];
            if (req_grant[i] && !rx_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rx_hit[i] && !req_grant[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic [15:0] tot_q, tot_d;

    always_comb begin
        has_credit       = '1;
        none_outstanding = (tot_q == '0);
        tot_d            = tot_q;
        if (found && !rx_ok) begin
            tot_d = tot_q + 16'd1;
        end else if (rx_ok && !found && (tot_q != '0)) begin
            tot_d = tot_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tot_q <= '0;
        end else begin
            tot_q <= tot_d;
        end
    end
`endif

    // Round-robin search starting at rr_q
    logic [N_REQ-1:0]  elig;
    logic [IDX_W-1:0]  gidx;
    logic [ADDR_W-1:0] sel_addr;
    logic [TAG_W-1:0]  sel_tag;

    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        j        = 0;
        jj       = '0;
        elig     = req_valid & has_credit & {N_REQ{!c0_tx_almfull && !reset}};
        found    = 1'b0;
        gidx     = '0;
        sel_addr = '0;
        sel_tag  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            j = int'(rr_q) + off;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IDX_W'(j);
            if (!found && elig[jj]) begin
                found    = 1'b1;
                gidx     = jj;
                sel_addr = addr_a[jj];
                sel_tag  = tag_a[jj];
            end
        end
        req_grant = found ? (N_REQ'(1) << gidx) : '0;
        if (!found) begin
            rr_d = rr_q;
        end else if (gidx == IDX_W'(N_REQ - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = gidx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            bad_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            tx_valid_q  <= found;
            if (found) begin
                tx_addr_q  <= sel_addr;
                tx_mdata_q <= {gidx, sel_tag};
            end
            rsp_valid_q <= rx_hit;
            if (rx_ok) begin
                rsp_tag_q  <= c0_rx_mdata[TAG_W-1:0];
                rsp_data_q <= c0_rx_data;
            end
            if (c0_rx_valid && !rx_ok) begin
                bad_q <= 1'b1;
            end
        end
    end

    assign c0_tx_valid = tx_valid_q;
    assign c0_tx_addr  = tx_addr_q;
    assign c0_tx_mdata = tx_mdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_data    = rsp_data_q;
    assign bad_rsp     = bad_q;
    assign idle        = !tx_valid_q && none_outstanding;

endmodule

// File: tb/tb_test_rd_req_arbiter.sv
module tb_test_rd_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 42;
    localparam int TW = 12;
    localparam int MW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  vld;
    logic [N*AW-1:0] addr;
    logic [N*TW-1:0] tag;
    logic          af, rxv;
    logic [MW-1:0] rxmd;
    logic [511:0]  rxd;
    logic [N-1:0]  gnt, rspv;
    logic          txv, bad, idl;
    logic [AW-1:0] txa;
    logic [MW-1:0] txm;
    logic [TW-1:0] rspt;
    logic [511:0]  rspd;

    test_rd_req_arbiter u_dut (
        .clk(clk), .reset(reset), .req_valid(vld), .req_addr(addr), .req_tag(tag),
        .req_grant(gnt), .c0_tx_valid(txv), .c0_tx_addr(txa), .c0_tx_mdata(txm),
        .c0_tx_almfull(af), .c0_rx_valid(rxv), .c0_rx_mdata(rxmd), .c0_rx_data(rxd),
        .rsp_valid(rspv), .rsp_tag(rspt), .rsp_data(rspd), .bad_rsp(bad), .idle(idl)
    );

    // Three-requester instance for the out-of-range index case
    logic [2:0]      r3_vld, r3_gnt, r3_rspv;
    logic [3*AW-1:0] r3_addr;
    logic [3*TW-1:0] r3_tag;
    logic            r3_af, r3_rxv, r3_txv, r3_bad, r3_idl;
    logic [MW-1:0]   r3_rxmd, r3_txm;
    logic [AW-1:0]   r3_txa;
    logic [TW-1:0]   r3_rspt;
    logic [511:0]    r3_rspd;

    test_rd_req_arbiter #(.N_REQ(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(r3_vld), .req_addr(r3_addr), .req_tag(r3_tag),
        .req_grant(r3_gnt), .c0_tx_valid(r3_txv), .c0_tx_addr(r3_txa), .c0_tx_mdata(r3_txm),
        .c0_tx_almfull(r3_af), .c0_rx_valid(r3_rxv), .c0_rx_mdata(r3_rxmd), .c0_rx_data(rxd),
        .rsp_valid(r3_rspv), .rsp_tag(r3_rspt), .rsp_data(r3_rspd), .bad_rsp(r3_bad), .idle(r3_idl)
    );

`ifdef TEST_RD_ARB_CREDIT_EN
    logic [N-1:0]    c_vld, c_gnt, c_rspv;
    logic            c_af, c_rxv, c_txv, c_bad, c_idl;
    logic [MW-1:0]   c_rxmd, c_txm;
    logic [AW-1:0]   c_txa;
    logic [TW-1:0]   c_rspt;
    logic [511:0]    c_rspd;

    test_rd_req_arbiter #(.MAX_OUTSTANDING(2)) u_dut_cr (
        .clk(clk), .reset(reset), .req_valid(c_vld), .req_addr(addr), .req_tag(tag),
        .req_grant(c_gnt), .c0_tx_valid(c_txv), .c0_tx_addr(c_txa), .c0_tx_mdata(c_txm),
        .c0_tx_almfull(c_af), .c0_rx_valid(c_rxv), .c0_rx_mdata(c_rxmd), .c0_rx_data(rxd),
        .rsp_valid(c_rspv), .rsp_tag(c_rspt), .rsp_data(c_rspd), .bad_rsp(c_bad), .idle(c_idl)
    );
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct { logic v; logic [AW-1:0] a; logic [MW-1:0] m; } tx_exp_t;
    typedef struct { logic [N-1:0] v; logic [TW-1:0] t; logic [511:0] d; } rsp_exp_t;
    typedef struct { logic [N-1:0] v; logic a; logic [N-1:0] eg; } vec_t;

    tx_exp_t  txq[$];
    rsp_exp_t rq[$];

    // One cycle on the main instance. Called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [N-1:0] v, input logic a, input logic rv,
                        input logic [MW-1:0] rm, input logic [N-1:0] eg, input string nm);
        tx_exp_t  te, tp;
        rsp_exp_t re, rp;
        cyc++;
        vld = v; af = a; rxv = rv; rxmd = rm;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = AW'(64'h2_0000_0000 + 64'(cyc * 16 + i));
            tag[i*TW +: TW]  = TW'(cyc * 4 + i);
        end
        for (int k = 0; k < 16; k++) rxd[k*32 +: 32] = $urandom;
        #3;
        if (txq.size() == 0 || rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: scoreboard empty got 0 expected 1", nm);
        end else begin
            tp = txq.pop_front();
            chk({nm, "_txv"}, txv, tp.v);
            if (tp.v) begin
                chk({nm, "_txa"}, txa, tp.a);
                chk({nm, "_txm"}, txm, tp.m);
            end
            rp = rq.pop_front();
            chk({nm, "_rspv"}, rspv, rp.v);
            if (rp.v != '0) begin
                chk({nm, "_rspt"}, rspt, rp.t);
                chk({nm, "_rspd"}, rspd, rp.d);
            end
        end
        chk({nm, "_gnt"}, gnt, eg);
        te = '{1'b0, '0, '0};
        for (int i = 0; i < N; i++) begin
            if (eg[i]) te = '{1'b1, addr[i*AW +: AW], {2'(i), tag[i*TW +: TW]}};
        end
        txq.push_back(te);
        re = '{'0, '0, '0};
        if (rv) re = '{4'b0001 << rm[MW-1:TW], rm[TW-1:0], rxd};
        rq.push_back(re);
        @(posedge clk); #1;
    endtask

    task automatic seed_sb();
        txq.delete(); rq.delete();
        txq.push_back('{1'b0, '0, '0});
        rq.push_back('{'0, '0, '0});
    endtask

    vec_t tbl[20];

    initial begin
        // Arbitration vectors from reset (rr = 0)
        for (int k = 0; k < 8; k++) tbl[k] = '{4'hF, 1'b0, 4'(1 << (k % 4))};
        tbl[8]  = '{4'hA, 1'b0, 4'h2};
        tbl[9]  = '{4'hA, 1'b0, 4'h8};
        tbl[10] = '{4'hA, 1'b0, 4'h2};
        for (int k = 11; k < 16; k++) tbl[k] = '{4'hF, 1'b1, 4'h0};
        tbl[16] = '{4'hF, 1'b0, 4'h4};
        tbl[17] = '{4'hF, 1'b0, 4'h8};
        tbl[18] = '{4'hF, 1'b0, 4'h1};
        tbl[19] = '{4'h0, 1'b0, 4'h0};

        reset = 1'b1; vld = 4'hF; af = 1'b0; rxv = 1'b0; rxmd = '0; rxd = '0;
        addr = '0; tag = '0;
        r3_vld = '0; r3_addr = '0; r3_tag = '0; r3_af = 1'b0; r3_rxv = 1'b0; r3_rxmd = '0;
`ifdef TEST_RD_ARB_CREDIT_EN
        c_vld = '0; c_af = 1'b0; c_rxv = 1'b0; c_rxmd = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 4'h0);
        chk("rst_txv", txv, 1'b0);
        chk("rst_rspv", rspv, 4'h0);
        chk("rst_bad", bad, 1'b0);
        chk("rst_idle", idl, 1'b1);
        chk("rst_bad3", r3_bad, 1'b0);
        reset = 1'b0;
        seed_sb();

        for (int k = 0; k < 20; k++) step(tbl[k].v, tbl[k].a, 1'b0, '0, tbl[k].eg, "vec");
        chk("idle_busy", idl, 1'b0);

        // 14 reads are outstanding; return them plus one issued alongside a response
        step(4'h0, 1'b0, 1'b1, {2'd2, 12'hABC}, 4'h0, "rsp_abc");
        step(4'h0, 1'b0, 1'b1, {2'd0, 12'h001}, 4'h0, "rsp_001");
        for (int k = 0; k < 11; k++)
            step(4'h0, 1'b0, 1'b1, {2'(k % 4), 12'(k + 16)}, 4'h0, "rsp_loop");
        step(4'h1, 1'b0, 1'b1, {2'd3, 12'h055}, 4'h1, "gnt_and_rsp");
        chk("idle_last", idl, 1'b0);
        step(4'h0, 1'b0, 1'b1, {2'd1, 12'h066}, 4'h0, "rsp_final");
        step(4'h0, 1'b0, 1'b0, '0, 4'h0, "drain");
        chk("idle_done", idl, 1'b1);

        // Reset abandons an in-flight read; its late response is still delivered
        step(4'hF, 1'b0, 1'b0, '0, 4'h2, "pre_rst");
        reset = 1'b1; vld = 4'hF;
        #3;
        chk("midrst_gnt", gnt, 4'h0);
        @(posedge clk); #1;
        chk("midrst_txv", txv, 1'b0);
        chk("midrst_idle", idl, 1'b1);
        reset = 1'b0;
        seed_sb();
        step(4'h0, 1'b0, 1'b1, {2'd1, 12'h777}, 4'h0, "late_rsp");
        step(4'h0, 1'b0, 1'b0, '0, 4'h0, "late_drain");
        chk("late_idle", idl, 1'b1);

        // Three requesters: index 3 is out of range
        r3_rxv = 1'b1; r3_rxmd = {2'd3, 12'h123};
        @(posedge clk); #1;
        r3_rxv = 1'b0;
        chk("n3_bad_rspv", r3_rspv, 3'b000);
        chk("n3_bad_set", r3_bad, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("n3_bad_sticky", r3_bad, 1'b1);
        for (int k = 0; k < 10; k++) begin
            r3_vld = 3'b001; r3_tag[TW-1:0] = TW'(k);
            #3;
            chk("n3_gnt", r3_gnt, 3'b001);
            @(posedge clk); #1;
        end
        r3_vld = 3'b000;
        chk("n3_txv", r3_txv, 1'b1);
        chk("n3_txm", r3_txm, {2'd0, 12'd9});
        for (int k = 0; k < 10; k++) begin
            if (k == 9) chk("n3_idle_busy", r3_idl, 1'b0);
            r3_rxv = 1'b1; r3_rxmd = {2'd0, 12'(k)};
            @(posedge clk); #1;
            chk("n3_rspv", r3_rspv, 3'b001);
            chk("n3_rspt", r3_rspt, 12'(k));
        end
        chk("n3_idle", r3_idl, 1'b1);
        r3_rxmd = {2'd2, 12'h3C3};
        @(posedge clk); #1;
        r3_rxv = 1'b0;
        chk("n3_rsp_top", r3_rspv, 3'b100);
        chk("n3_rsp_top_tag", r3_rspt, 12'h3C3);
        chk("n3_idle_sat", r3_idl, 1'b1);
        chk("n3_bad_hold", r3_bad, 1'b1);

`ifdef TEST_RD_ARB_CREDIT_EN
        begin
            logic [N-1:0] cv [10];
            logic         crx [10];
            logic [N-1:0] ceg [10];
            cv  = '{4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1, 4'h1};
            crx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            ceg = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0};
            for (int k = 0; k < 10; k++) begin
                c_vld = cv[k]; c_rxv = crx[k]; c_rxmd = {2'd0, 12'h0};
                #3;
                chk("cr_gnt", c_gnt, ceg[k]);
                @(posedge clk); #1;
            end
            c_vld = '0; c_rxv = 1'b0;
        end
`endif

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("n3_bad_clr", r3_bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_rd_req_arbiter.md
# test_rd_req_arbiter

Round-robin arbiter that shares the single CCI-P c0 read-request channel on the MPF AFU-side interface between N_REQ independent test engines inside test_afu. It tags each request's Mdata with the requester index, honors c0TxAlmFull, optionally limits outstanding reads per requester, and steers each read response back to the requester that issued it.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 42, line address width
- TAG_W, 12, requester-private tag width
- MAX_OUTSTANDING, 32, per-requester outstanding-read limit (used only with the credit feature)
- IDX_W, $clog2(N_REQ), derived localparam; Mdata width is TAG_W+IDX_W (≤16)

Ports:
- clk  in  1  AFU clock
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  request pending per requester
- req_addr  in  N_REQ*ADDR_W  line address, requester i at slice i
- req_tag  in  N_REQ*TAG_W  requester tag
- req_grant  out  N_REQ  one-hot accept, combinational; transfer when req_valid[i] & req_grant[i]
- c0_tx_valid  out  1  read request to MPF
- c0_tx_addr  out  ADDR_W  request address
- c0_tx_mdata  out  TAG_W+IDX_W  {index, tag}
- c0_tx_almfull  in  1  MPF c0TxAlmFull
- c0_rx_valid  in  1  read response
- c0_rx_mdata  in  TAG_W+IDX_W  response Mdata
- c0_rx_data  in  512  response line
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_tag  out  TAG_W  returned tag
- rsp_data  out  512  returned line
- bad_rsp  out  1  sticky: response with index ≥ N_REQ
- idle  out  1  no outstanding reads and no request in flight

## Operation
- Eligibility of requester i: req_valid[i], !c0_tx_almfull, and (credit feature) cnt[i] < MAX_OUTSTANDING.
- Round-robin pointer rr (IDX_W bits): search eligible requesters starting at rr, wrapping at N_REQ; the first hit is granted. At most one grant per cycle.
- On grant to i: rr ← (i+1) mod N_REQ; register {valid, req_addr[i], {i, req_tag[i]}} into the c0_tx outputs. No grant → c0_tx_valid=0 next cycle, rr unchanged.
- c0_tx_almfull asserted → req_grant=0 in that cycle. The one request registered in the prior cycle is still issued; CCI-P almost-full slack covers it.
- Response: c0_rx_valid with index k<N_REQ → next cycle rsp_valid[k]=1, rsp_tag=c0_rx_mdata[TAG_W-1:0], rsp_data=c0_rx_data. Index ≥ N_REQ (N_REQ not a power of 2) → dropped, bad_rsp set until reset.
- Responses are never back-pressured; requesters must always accept rsp_valid.
- idle = !c0_tx_valid && (credit feature: all cnt==0; otherwise a single total-outstanding counter is 0).
- Reset: rr=0, c0_tx_valid=0, rsp_valid=0, bad_rsp=0, all counters 0, c0_tx_addr/c0_tx_mdata/rsp_tag/rsp_data don't-care but are driven 0. req_grant is 0 during reset. Reset mid-operation abandons in-flight reads; responses for them that arrive after reset are delivered normally, and counters saturate at 0 rather than underflowing.

## Timing
- Grant → c0_tx_valid: 1 cycle (registered output).
- c0_rx → rsp_valid: 1 cycle (registered output).
- Throughput: 1 request/cycle, 1 response/cycle, concurrently.
- Counter width: $clog2(MAX_OUTSTANDING+1). Grant and response to the same requester in the same cycle → count unchanged.
- The total-outstanding counter used for idle is 16 bits, with the same grant/response rules.

## Configuration
- TEST_RD_ARB_CREDIT_EN defined: per-requester counters; a requester at MAX_OUTSTANDING is ineligible and is skipped by round-robin without stalling others. idle uses the per-requester counters.
- Not defined: no per-requester counters and no limit. Eligibility is req_valid & !c0_tx_almfull. idle uses the 16-bit total counter.

## Test plan
- All 4 requesters valid continuously, almfull=0 → grants cycle 0,1,2,3,0…; c0_tx_mdata[13:12] follows 0,1,2,3 one cycle after each grant.
- Only requesters 1 and 3 valid, rr=0 → grant 1, then 3, then 1; no grant to idle requesters.
- almfull asserted for 5 cycles while all valid → req_grant=0 for exactly those 5 cycles; rr resumes at the next index after the last grant.
- Responses with mdata {2, 0xABC} and {0, 0x001} on back-to-back cycles → rsp_valid=0100 with tag 0xABC, then 0001 with tag 0x001, each one cycle later with data intact.
- With TEST_RD_ARB_CREDIT_EN and MAX_OUTSTANDING=2: requester 0 issues 2 reads with no responses → requester 0 is skipped while 1–3 are granted; after one response to 0 it is granted again; simultaneous grant and response leaves cnt[0]=1.
- N_REQ=3, response with index 3 → no rsp_valid and bad_rsp=1 until reset; after 10 requests and 10 responses, idle=1.
